// File: rtl/i2c_wr_master.sv
// Write-only two-wire master: sends {DEV_ADDR,0}, data[15:8], data[7:0] per request.
// Every non-idle state lasts one slot of four QDIV-cycle quarters.
//
//  state | meaning
//  IDLE  | bus released, waiting for i2c_exec
//  START | SDA falls while SCL high
//  BYTE  | one data bit per slot, MSB first
//  ACK   | SDA released, slave ACK sampled late in SCL high
//  STOP  | SDA rises while SCL high, then i2c_done
module i2c_wr_master #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter logic [7:0] QDIV     = 8'd50
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        i2c_exec,
    input  logic [15:0] i2c_data,
    input  logic        sda_in,
    output logic        scl,
    output logic        sda_oe,
    output logic        i2c_done,
    output logic        i2c_ack,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP} state_t;

    state_t      state, state_nx;
    logic [7:0]  qcnt, qcnt_nx;
    logic [1:0]  quarter, quarter_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic [1:0]  byte_idx, byte_idx_nx;
    logic [15:0] data_q, data_nx;
    logic        nack_smp, nack_smp_nx;
    logic        scl_nx, sda_oe_nx, done_nx, ack_nx, busy_nx;
    logic [7:0]  cur_byte;
    logic        q_end, slot_end;

    assign q_end    = (qcnt == QDIV - 8'd1);
    assign slot_end = q_end && (quarter == 2'd3);

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= IDLE;
            qcnt     <= 8'd0;
            quarter  <= 2'd0;
            bit_idx  <= 3'd7;
            byte_idx <= 2'd0;
            data_q   <= 16'd0;
            nack_smp <= 1'b0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
            i2c_done <= 1'b0;
            i2c_ack  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            qcnt     <= qcnt_nx;
            quarter  <= quarter_nx;
            bit_idx  <= bit_idx_nx;
            byte_idx <= byte_idx_nx;
            data_q   <= data_nx;
            nack_smp <= nack_smp_nx;
            scl      <= scl_nx;
            sda_oe   <= sda_oe_nx;
            i2c_done <= done_nx;
            i2c_ack  <= ack_nx;
            busy     <= busy_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        qcnt_nx     = qcnt;
        quarter_nx  = quarter;
        bit_idx_nx  = bit_idx;
        byte_idx_nx = byte_idx;
        data_nx     = data_q;
        nack_smp_nx = nack_smp;
        done_nx     = 1'b0;
        ack_nx      = i2c_ack;
        busy_nx     = busy;

        if (state != IDLE) begin
            if (q_end) begin
                qcnt_nx    = 8'd0;
                quarter_nx = quarter + 2'd1;
            end else begin
                qcnt_nx = qcnt + 8'd1;
            end
        end

        case (state)
            IDLE: begin
                if (i2c_exec) begin
                    state_nx   = START;
                    data_nx    = i2c_data;
                    ack_nx     = 1'b0;
                    busy_nx    = 1'b1;
                    qcnt_nx    = 8'd0;
                    quarter_nx = 2'd0;
                end
            end
            START: begin
                if (slot_end) begin
                    state_nx    = BYTE;
                    byte_idx_nx = 2'd0;
                    bit_idx_nx  = 3'd7;
                end
            end
            BYTE: begin
                if (slot_end) begin
                    if (bit_idx == 3'd0) state_nx = ACK;
                    else                 bit_idx_nx = bit_idx - 3'd1;
                end
            end
            ACK: begin
                if (quarter == 2'd2 && q_end) nack_smp_nx = sda_in;
                if (slot_end) begin
                    if (nack_smp) begin
                        ack_nx   = 1'b1;
                        state_nx = STOP;
                    end else if (byte_idx == 2'd2) begin
                        state_nx = STOP;
                    end else begin
                        byte_idx_nx = byte_idx + 2'd1;
                        bit_idx_nx  = 3'd7;
                        state_nx    = BYTE;
                    end
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Pad levels are derived from the next state so they stay registered and aligned.
        cur_byte = {DEV_ADDR, 1'b0};
        case (byte_idx_nx)
            2'd1:    cur_byte = data_nx[15:8];
            2'd2:    cur_byte = data_nx[7:0];
            default: cur_byte = {DEV_ADDR, 1'b0};
        endcase

        scl_nx    = 1'b1;
        sda_oe_nx = 1'b0;
        case (state_nx)
            START: sda_oe_nx = quarter_nx[1];
            BYTE: begin
                scl_nx    = quarter_nx[1];
                sda_oe_nx = ~cur_byte[bit_idx_nx];
            end
            ACK:   scl_nx = quarter_nx[1];
            STOP: begin
                scl_nx    = quarter_nx[1];
                sda_oe_nx = (quarter_nx != 2'd3);
            end
            default: ;
        endcase
    end

endmodule

// File: doc/i2c_wr_master.md
# i2c_wr_master

Two-wire write-only master that executes the register-write requests issued by the codec configuration sequencer. Each accepted request is a 16-bit WM8978 control word. It is sent as a 3-byte write frame: device address byte, then `i2c_data[15:8]`, then `i2c_data[7:0]`. Completion is reported back on `i2c_done`. The block sits between the configuration sequencer and the top-level SCL/SDA pads; the SDA tristate buffer is at top level.

## Interface
- `DEV_ADDR`, default 7'h1A: 7-bit target address; R/W bit is always 0.
- `QDIV`, default 8'd50: clk cycles per SCL quarter-period. Legal range 2..255. Default gives 250 kHz SCL at 50 MHz clk.
- `clk`  input  1: clock; shared with the configuration sequencer.
- `sys_rst`  input  1: reset, asynchronous, active-low.
- `i2c_exec`  input  1: request strobe. Sampled only in IDLE.
- `i2c_data`  input  16: word to write. Captured on the cycle `i2c_exec` is accepted.
- `sda_in`  input  1: SDA pad readback.
- `scl`  output  1: SCL, push-pull.
- `sda_oe`  output  1: 1 = pull SDA low, 0 = release SDA (external pull-up).
- `i2c_done`  output  1: one-cycle pulse at end of frame.
- `i2c_ack`  output  1: NACK flag. 1 = a NACK was seen in the last frame. Cleared when a new request is accepted.
- `busy`  output  1: high from request acceptance until `i2c_done`.

## Operation
- States: IDLE, START, BYTE, ACK, STOP.
- Byte index (0..2) selects the byte: {DEV_ADDR,1'b0}, then i2c_data[15:8], then i2c_data[7:0]. Bits are sent MSB first.
- IDLE -> START when `i2c_exec`=1.
  - On that edge: latch `i2c_data`, clear `i2c_ack`, set `busy`.
- START -> BYTE, byte index 0, bit counter 7.
- BYTE: one bit per slot.
  - `sda_oe` = ~bit.
  - After the bit-0 slot -> ACK.
- ACK: `sda_oe`=0; sample `sda_in`.
  - 0 and index < 2: increment index -> BYTE.
  - 0 and index = 2: -> STOP.
  - 1 (NACK): set `i2c_ack`=1 -> STOP. Remaining bytes are abandoned.
- STOP -> IDLE, with `i2c_done`=1 for exactly one cycle. `busy` goes low on the same edge.
- `i2c_exec` while busy: ignored. No queueing, no effect on the current frame.
- `i2c_exec` in the cycle directly after `i2c_done`: accepted, because the block is already in IDLE.
- Quarter counter 0..QDIV-1 and quarter index q0..q3. Every state except IDLE lasts one slot = 4·QDIV cycles.

## Timing
- Reset values, applied asynchronously; a reset mid-frame releases the bus immediately:
  - `scl`=1, `sda_oe`=0, `i2c_done`=0, `i2c_ack`=0, `busy`=0, state IDLE.
- IDLE levels: `scl`=1, `sda_oe`=0.
- START slot:
  - `scl`=1 for all four quarters.
  - `sda_oe`=0 in q0–q1, 1 in q2–q3. This is SDA falling while SCL is high.
- BYTE/ACK slot:
  - `scl`=0 in q0–q1, 1 in q2–q3.
  - `sda_oe` changes only on the first cycle of q0, while SCL is low.
  - `sda_in` is sampled on the last cycle of q2.
- STOP slot:
  - `scl`=0 in q0–q1, 1 in q2–q3.
  - `sda_oe`=1 in q0–q2, 0 in q3. This is SDA rising while SCL is high.
- Full frame length: 1 + 27 + 1 = 29 slots = 116·QDIV cycles.
  - `i2c_done` is high in the cycle starting exactly 116·QDIV edges after the accepting edge.
- NACK at byte k (k = 0, 1 or 2): frame length is (1 + 9·(k+1) + 1)·4·QDIV cycles.
- `i2c_ack` is valid while `i2c_done`=1 and holds until the next acceptance.
- Outputs are registered; none is driven combinationally from an input.

## Test plan
- Nominal write, QDIV=2, i2c_data=16'h022F, slave ACKs every byte:
  - SDA decodes as bytes 0x34, 0x02, 0x2F.
  - START and STOP are correctly formed.
  - `i2c_done` pulses once, 232 cycles after acceptance; `i2c_ack`=0.
- NACK on the address byte (sda_in held high):
  - STOP begins right after the first ACK slot.
  - `i2c_done` arrives 88 cycles after acceptance; `i2c_ack`=1.
  - `i2c_ack` clears on the next accepted request.
- `i2c_exec` pulsed at cycles 10 and 100 of a frame:
  - No effect; the frame is bit-identical to the nominal case.
  - Exactly one `i2c_done`.
- Back-to-back: `i2c_exec` asserted the cycle after `i2c_done`, with words 16'h0001 then 16'h0C6F:
  - Second START begins immediately.
  - Bytes decode as 0x34 0x00 0x01 then 0x34 0x0C 0x6F.
- Reset asserted mid-byte 1:
  - Same edge: `scl`=1, `sda_oe`=0, `busy`=0, no `i2c_done`.
  - After release, a new request completes normally.
- 19-word sequence driven by the configuration sequencer:
  - 19 frames on the bus, 19 `i2c_done` pulses.
  - SCL high/low quarter widths are exactly QDIV cycles throughout.
